// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO.
// Frames are start bit, LSB-first data, optional parity bit, then stop bits.
// Back-to-back frames leave no idle bit between the stop and the next start.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                uart_tx_bclk,
    input  logic                                uart_tx_rst,
    input  logic                                uart_tx_valid,
    input  logic [DATA_BITS-1:0]                uart_tx_data,
    output logic                                uart_tx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     uart_tx_level,
    output logic                                uart_tx_pin,
    output logic                                uart_tx_busy
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_RELOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 1");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..256");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   pin_q, pin_d;
    logic                   busy_q, busy_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   push, pop, head_par;
    logic [DATA_BITS-1:0]   head;

    assign push     = uart_tx_valid && (level_q != FULL);
    assign head     = mem_q[rd_ptr_q];
    assign head_par = (PARITY == 1) ? ~(^head) : (^head);

    // Frame sequencer: pops the head word into the shifter and walks the bits.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        pin_d    = pin_q;
        pop      = 1'b0;
        if (state_q == IDLE) begin
            pin_d = 1'b1;
            if (level_q != '0) begin
                pop      = 1'b1;
                state_d  = START;
                pin_d    = 1'b0;
                timer_d  = T_RELOAD;
                bitcnt_d = '0;
                shreg_d  = head;
                par_d    = head_par;
            end
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end else begin
            timer_d = T_RELOAD;
            case (state_q)
                START: begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                    pin_d    = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                end
                DATA: begin
                    if (bitcnt_q == LAST_DATA) begin
                        bitcnt_d = '0;
                        if (PARITY != 0) begin
                            state_d = PAR;
                            pin_d   = par_q;
                        end else begin
                            state_d = STOP;
                            pin_d   = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        pin_d    = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                    end
                end
                PAR: begin
                    state_d  = STOP;
                    bitcnt_d = '0;
                    pin_d    = 1'b1;
                end
                STOP: begin
                    if (bitcnt_q == LAST_STOP) begin
                        bitcnt_d = '0;
                        if (level_q != '0) begin
                            // chain straight into the next start bit
                            pop     = 1'b1;
                            state_d = START;
                            pin_d   = 1'b0;
                            shreg_d = head;
                            par_d   = head_par;
                        end else begin
                            state_d = IDLE;
                            pin_d   = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        pin_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pin_d   = 1'b1;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy update; push and pop together keep level.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (!push && pop)
            level_d = level_q - LW'(1);
        busy_d = (state_d != IDLE) || (level_d != '0);
    end

    // Control state; reset aborts any frame and empties the FIFO at once.
    always_ff @(posedge uart_tx_bclk or posedge uart_tx_rst) begin
        if (uart_tx_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            pin_q    <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            pin_q    <= pin_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge uart_tx_bclk) begin
        if (push)
            mem_q[wr_ptr_q] <= uart_tx_data;
    end

    assign uart_tx_ready = (level_q != FULL);
    assign uart_tx_level = level_q;
    assign uart_tx_pin   = pin_q;
    assign uart_tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances with different frame formats share
// one clock and reset; frames are sampled every cycle and compared to
// hand-written bit sequences (bit i of an expected vector = i-th bit on the line).
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       valid_a [4];
    logic [8:0] data_a  [4];
    logic       ready_a [4];
    logic       pin_a   [4];
    logic       busy_a  [4];
    logic [2:0] level_a [4];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8N1, 4 clocks per bit
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u0 (
        .uart_tx_bclk(clk), .uart_tx_rst(rst), .uart_tx_valid(valid_a[0]), .uart_tx_data(data_a[0][7:0]),
        .uart_tx_ready(ready_a[0]), .uart_tx_level(level_a[0]), .uart_tx_pin(pin_a[0]), .uart_tx_busy(busy_a[0]));
    // 8E1, bit clock
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u1 (
        .uart_tx_bclk(clk), .uart_tx_rst(rst), .uart_tx_valid(valid_a[1]), .uart_tx_data(data_a[1][7:0]),
        .uart_tx_ready(ready_a[1]), .uart_tx_level(level_a[1]), .uart_tx_pin(pin_a[1]), .uart_tx_busy(busy_a[1]));
    // 8O1, bit clock
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u2 (
        .uart_tx_bclk(clk), .uart_tx_rst(rst), .uart_tx_valid(valid_a[2]), .uart_tx_data(data_a[2][7:0]),
        .uart_tx_ready(ready_a[2]), .uart_tx_level(level_a[2]), .uart_tx_pin(pin_a[2]), .uart_tx_busy(busy_a[2]));
    // 5N2, bit clock
    uart_tx_fifo #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u3 (
        .uart_tx_bclk(clk), .uart_tx_rst(rst), .uart_tx_valid(valid_a[3]), .uart_tx_data(data_a[3][4:0]),
        .uart_tx_ready(ready_a[3]), .uart_tx_level(level_a[3]), .uart_tx_pin(pin_a[3]), .uart_tx_busy(busy_a[3]));

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic [11:0] bits;
        int         nbits;
        int         cpb;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int inst, input logic [8:0] d);
        valid_a[inst] = 1'b1;
        data_a[inst]  = d;
        tick();
        valid_a[inst] = 1'b0;
    endtask

    // Push one word into an idle instance and sample the whole frame.
    task automatic send_frame(input int inst, input logic [8:0] d, input logic [11:0] bits,
                              input int nb, input int cpb, input string nm);
        logic [63:0] got, expv;
        logic        busy0;
        got  = '0;
        expv = '0;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < cpb; c++)
                expv[b*cpb+c] = bits[b];
        push(inst, d);
        tick();
        busy0 = busy_a[inst];
        for (int k = 0; k < nb*cpb; k++) begin
            got[k] = pin_a[inst];
            tick();
        end
        chk({nm, " frame"}, got, expv);
        chk({nm, " busy during"}, 64'(busy0), 64'd1);
        chk({nm, " pin idle after"}, 64'(pin_a[inst]), 64'd1);
        chk({nm, " busy after"}, 64'(busy_a[inst]), 64'd0);
    endtask

    // Six words with valid held high through a 4-deep FIFO; frames must be
    // back-to-back and in order.
    task automatic seq_fifo_full();
        logic [7:0]  w [6];
        int          k, cyc, wt;
        logic        rdy, saw_full;
        logic [63:0] got, expv;
        w = '{8'h31, 8'h4C, 8'hA7, 8'h0F, 8'hF0, 8'h96};
        k = 0;
        cyc = 0;
        wt = 0;
        saw_full = 1'b0;
        fork
            begin
                while (k < 6 && cyc < 400) begin
                    valid_a[0] = 1'b1;
                    data_a[0]  = {1'b0, w[k]};
                    rdy = ready_a[0];
                    if (!rdy && !saw_full) begin
                        saw_full = 1'b1;
                        chk("fifo level at ready low", 64'(level_a[0]), 64'd4);
                    end
                    tick();
                    if (rdy) k++;
                    cyc++;
                end
                valid_a[0] = 1'b0;
                chk("fifo all words accepted", 64'(k), 64'd6);
            end
            begin
                while (pin_a[0] !== 1'b0 && wt < 20) begin
                    tick();
                    wt++;
                end
                chk("fifo first start seen", 64'(pin_a[0]), 64'd0);
                for (int f = 0; f < 6; f++) begin
                    got  = '0;
                    expv = '0;
                    for (int b = 0; b < 10; b++)
                        for (int c = 0; c < 4; c++)
                            expv[b*4+c] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[f][b-1];
                    for (int s = 0; s < 40; s++) begin
                        got[s] = pin_a[0];
                        tick();
                    end
                    chk($sformatf("fifo frame %0d", f), got, expv);
                end
            end
        join
        chk("fifo ready went low", 64'(saw_full), 64'd1);
        chk("fifo pin idle after", 64'(pin_a[0]), 64'd1);
        chk("fifo busy after", 64'(busy_a[0]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        int          bad_idle, wt;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_a[i] = 1'b0;
            data_a[i]  = '0;
        end
        tbl[0] = '{0, 9'h0A5, 12'b0011_0100_1010, 10, 4};
        tbl[1] = '{1, 9'h007, 12'b0110_0000_1110, 11, 1};
        tbl[2] = '{2, 9'h007, 12'b0100_0000_1110, 11, 1};
        tbl[3] = '{1, 9'h000, 12'b0100_0000_0000, 11, 1};
        tbl[4] = '{2, 9'h000, 12'b0110_0000_0000, 11, 1};
        tbl[5] = '{1, 9'h081, 12'b0101_0000_0010, 11, 1};
        tbl[6] = '{2, 9'h081, 12'b0111_0000_0010, 11, 1};
        tbl[7] = '{3, 9'h01F, 12'b0000_1111_1110, 8, 1};
        tbl[8] = '{3, 9'h000, 12'b0000_1100_0000, 8, 1};

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset pin u%0d", i), 64'(pin_a[i]), 64'd1);
            chk($sformatf("reset busy u%0d", i), 64'(busy_a[i]), 64'd0);
            chk($sformatf("reset level u%0d", i), 64'(level_a[i]), 64'd0);
            chk($sformatf("reset ready u%0d", i), 64'(ready_a[i]), 64'd1);
        end
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            send_frame(tbl[i].inst, tbl[i].data, tbl[i].bits, tbl[i].nbits, tbl[i].cpb,
                       $sformatf("vec%0d", i));

        // 5N2: two frames back to back, two stop bits between them
        valid_a[3] = 1'b1;
        data_a[3]  = 9'h01F;
        tick();
        data_a[3]  = 9'h000;
        tick();
        valid_a[3] = 1'b0;
        got = '0;
        for (int s = 0; s < 16; s++) begin
            got[s] = pin_a[3];
            tick();
        end
        chk("5n2 two frames", got, 64'b1100_0000_1111_1110);
        chk("5n2 pin idle after", 64'(pin_a[3]), 64'd1);

        // bit clock: push on the same edge as the chained pop at level 2
        valid_a[1] = 1'b1;
        data_a[1]  = 9'h021;
        tick();
        data_a[1]  = 9'h022;
        tick();
        data_a[1]  = 9'h023;
        tick();
        valid_a[1] = 1'b0;
        chk("pushpop level before", 64'(level_a[1]), 64'd2);
        repeat (9) tick();
        chk("pushpop level at last stop", 64'(level_a[1]), 64'd2);
        valid_a[1] = 1'b1;
        data_a[1]  = 9'h024;
        tick();
        valid_a[1] = 1'b0;
        chk("pushpop level same edge", 64'(level_a[1]), 64'd2);
        chk("pushpop next start no gap", 64'(pin_a[1]), 64'd0);
        wt = 0;
        while (busy_a[1] !== 1'b0 && wt < 100) begin
            tick();
            wt++;
        end
        chk("pushpop drained", 64'(busy_a[1]), 64'd0);

        seq_fifo_full();

        // reset in the middle of a data bit with three words queued
        valid_a[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_a[0] = 9'(8'h11 * (i + 1));
            tick();
        end
        valid_a[0] = 1'b0;
        chk("midrst level queued", 64'(level_a[0]), 64'd3);
        repeat (4) tick();
        #2 rst = 1'b1;
        valid_a[0] = 1'b1;
        #1;
        chk("midrst pin async", 64'(pin_a[0]), 64'd1);
        chk("midrst level async", 64'(level_a[0]), 64'd0);
        chk("midrst busy async", 64'(busy_a[0]), 64'd0);
        chk("midrst ready async", 64'(ready_a[0]), 64'd1);
        tick();
        chk("midrst valid ignored", 64'(level_a[0]), 64'd0);
        valid_a[0] = 1'b0;
        rst = 1'b0;
        bad_idle = 0;
        for (int s = 0; s < 30; s++) begin
            tick();
            if (pin_a[0] !== 1'b1 || busy_a[0] !== 1'b0) bad_idle++;
        end
        chk("midrst no frame after release", 64'(bad_idle), 64'd0);

        // valid held through reset is taken on the first edge after release
        rst = 1'b1;
        valid_a[0] = 1'b1;
        data_a[0]  = 9'h03C;
        tick();
        chk("rst hold level", 64'(level_a[0]), 64'd0);
        rst = 1'b0;
        send_frame(0, 9'h03C, 12'b0010_0111_1000, 10, 4, "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
